// File: rtl/fbarb_pkg.sv
// Shared definitions for the frame buffer arbiter: owner encoding and default
// sizing constants.
package fbarb_pkg;

  // Port owner as held in the arbiter's owner register.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CAP  = 2'd2
  } owner_e;

  localparam int FB_ADDR_W    = 10;
  localparam int FB_DATA_W    = 8;
  localparam int FB_BURST_LEN = 8;
  localparam int FB_MAX_WAIT  = 32;
  localparam int FB_RD_LAT    = 1;

endpackage

// File: rtl/rd_valid_pipe.sv
// Read-valid delay line: shifts the display grant through DEPTH stages so the
// valid flag lines up with data returned by the RAM. Sync clear flushes it.
module rd_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr_i,
  input  logic vld_i,
  output logic vld_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // Next contents: new grant enters stage 0, older entries move one stage on.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = vld_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage registers; a clear drops every in-flight valid.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign vld_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/frame_buf_arbiter.sv
// Single-port frame buffer arbiter. Display reads have priority; capture
// writes are served in bursts and can force their way in after a bounded wait.
//
//  state | meaning
//  IDLE  | nobody owns the port, no grant this cycle
//  DISP  | display reader owns the port
//  CAP   | capture writer owns the port (burst in progress)
module frame_buf_arbiter
  import fbarb_pkg::*;
#(
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int BURST_LEN = FB_BURST_LEN,
  parameter int MAX_WAIT  = FB_MAX_WAIT,
  parameter int RD_LAT    = FB_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              cap_req,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_wdata,
  output logic              cap_gnt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       preempt_cnt,
  output logic              cap_starved,
  input  logic              stat_clr
);

  localparam int BURST_W = $clog2(BURST_LEN) + 1;
  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MAX_WAIT);

  owner_e              owner_q, owner_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [WAIT_W-1:0]   cap_wait_q, cap_wait_d;
  logic [15:0]         preempt_q, preempt_d;
  logic                starved_q, starved_d;
  logic                preempt_evt;
  logic                cap_reenter;
  logic                own_disp;
  logic                own_cap;
  logic                rvalid_raw;

  assign own_disp = (owner_q == OWN_DISP);
  assign own_cap  = (owner_q == OWN_CAP);

  // Grants come straight from the registered owner; reset forces them low
  // immediately so an in-flight access is dropped in the reset cycle.
  assign disp_gnt = rst_n & disp_req & own_disp;
  assign cap_gnt  = rst_n & cap_req & own_cap;
  assign ram_en   = disp_gnt | cap_gnt;
  assign ram_we   = cap_gnt;

  // Next-owner selection: display priority, wait-bounded preemption, burst cap.
  always_comb begin
    owner_d     = owner_q;
    preempt_evt = 1'b0;
    cap_reenter = 1'b0;
    case (owner_q)
      OWN_IDLE: begin
        if (disp_req) begin
          owner_d = OWN_DISP;
        end else if (cap_req) begin
          owner_d = OWN_CAP;
        end
      end
      OWN_DISP: begin
        if (cap_req && (cap_wait_q >= WAIT_MAX)) begin
          owner_d     = OWN_CAP;
          preempt_evt = 1'b1;
        end else if (disp_req) begin
          owner_d = OWN_DISP;
        end else if (cap_req) begin
          owner_d = OWN_CAP;
        end else begin
          owner_d = OWN_IDLE;
        end
      end
      OWN_CAP: begin
        if (cap_req && (burst_cnt_q < BURST_LAST)) begin
          owner_d = OWN_CAP;
        end else if (disp_req) begin
          owner_d = OWN_DISP;
        end else if (cap_req) begin
          owner_d     = OWN_CAP;
          cap_reenter = 1'b1;
        end else begin
          owner_d = OWN_IDLE;
        end
      end
      default: begin
        owner_d = OWN_IDLE;
      end
    endcase
  end

  // Burst length, capture wait and statistics next-state values.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    cap_wait_d  = cap_wait_q;
    preempt_d   = preempt_q;
    starved_d   = starved_q;

    // A fresh burst starts whenever the writer is (re)admitted.
    if ((owner_d != OWN_CAP) || cap_reenter) begin
      burst_cnt_d = '0;
    end else if (cap_gnt) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end

    if (cap_gnt) begin
      cap_wait_d = '0;
    end else if (cap_req && (cap_wait_q < WAIT_MAX)) begin
      cap_wait_d = cap_wait_q + WAIT_W'(1);
    end

    // Clear takes precedence over a same-cycle increment or set.
    if (stat_clr) begin
      preempt_d = '0;
      starved_d = 1'b0;
    end else begin
      if (preempt_evt && (preempt_q != 16'hFFFF)) begin
        preempt_d = preempt_q + 16'd1;
      end
      if (cap_wait_d == WAIT_MAX) begin
        starved_d = 1'b1;
      end
    end
  end

  // Owner, counters and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q     <= OWN_IDLE;
      burst_cnt_q <= '0;
      cap_wait_q  <= '0;
      preempt_q   <= '0;
      starved_q   <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      cap_wait_q  <= cap_wait_d;
      preempt_q   <= preempt_d;
      starved_q   <= starved_d;
    end
  end

  // RAM address/data mux follows the owner; parked at zero when idle or in reset.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    if (rst_n) begin
      case (owner_q)
        OWN_DISP: ram_addr = disp_addr;
        OWN_CAP: begin
          ram_addr  = cap_addr;
          ram_wdata = cap_wdata;
        end
        default: begin
          ram_addr  = '0;
          ram_wdata = '0;
        end
      endcase
    end
  end

  rd_valid_pipe #(
    .DEPTH(RD_LAT)
  ) u_rd_valid_pipe (
    .clk   (clk),
    .clr_i (~rst_n),
    .vld_i (disp_gnt),
    .vld_o (rvalid_raw)
  );

  assign disp_rvalid = rst_n & rvalid_raw;
  assign disp_rdata  = ram_rdata;
  assign preempt_cnt = rst_n ? preempt_q : 16'd0;
  assign cap_starved = rst_n & starved_q;

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Self-checking bench for frame_buf_arbiter: directed phases plus a random
// phase, all compared against a rule-level model of the arbiter and the RAM.
module tb_frame_buf_arbiter;

  localparam int MAXW   = 32;
  localparam int BLEN   = 8;
  localparam int M_IDLE = 0;
  localparam int M_DISP = 1;
  localparam int M_CAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req = 1'b0;
  logic [9:0]  disp_addr = '0;
  logic        disp_gnt;
  logic [7:0]  disp_rdata;
  logic        disp_rvalid;
  logic        cap_req = 1'b0;
  logic [9:0]  cap_addr = '0;
  logic [7:0]  cap_wdata = '0;
  logic        cap_gnt;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [15:0] preempt_cnt;
  logic        cap_starved;
  logic        stat_clr = 1'b0;

  always #5 clk = ~clk;

  frame_buf_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rdata  (disp_rdata),
    .disp_rvalid (disp_rvalid),
    .cap_req     (cap_req),
    .cap_addr    (cap_addr),
    .cap_wdata   (cap_wdata),
    .cap_gnt     (cap_gnt),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .preempt_cnt (preempt_cnt),
    .cap_starved (cap_starved),
    .stat_clr    (stat_clr)
  );

  // Buffer RAM model, read latency 1; unwritten words hold a seeded pattern.
  int         seed = 0;
  logic [7:0] mem [1024];
  bit         written [1024];

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 151 + seed);
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]     <= ram_wdata;
        written[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
      end
    end
  end

  // Reference model state.
  int         m_owner = M_IDLE;
  int         m_burst = 0;
  int         m_wait = 0;
  int         m_pre = 0;
  bit         m_starved = 0;
  bit         m_rv = 0;
  logic [7:0] m_rv_data = '0;
  bit         m_last_dg = 0;
  bit         m_last_cg = 0;
  bit         m_last_pre = 0;
  logic [7:0] shadow [1024];
  bit         sh_wr [1024];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic        obs_dg, obs_cg, obs_en, obs_we, obs_rv, obs_st;
  logic [7:0]  obs_rdata;
  logic [15:0] obs_pre;

  function automatic logic [7:0] expected_word(input logic [9:0] a);
    return sh_wr[a] ? shadow[a] : init_val(int'(a));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic       e_dg, e_cg;
    logic [9:0] e_addr;
    logic [7:0] e_wdata;
    e_dg    = rst_n && disp_req && (m_owner == M_DISP);
    e_cg    = rst_n && cap_req && (m_owner == M_CAP);
    e_addr  = '0;
    e_wdata = '0;
    if (rst_n && m_owner == M_DISP) e_addr = disp_addr;
    if (rst_n && m_owner == M_CAP) begin
      e_addr  = cap_addr;
      e_wdata = cap_wdata;
    end
    obs_dg = disp_gnt; obs_cg = cap_gnt; obs_en = ram_en; obs_we = ram_we;
    obs_rv = disp_rvalid; obs_rdata = disp_rdata; obs_pre = preempt_cnt; obs_st = cap_starved;
    chk("disp_gnt", disp_gnt, e_dg);
    chk("cap_gnt", cap_gnt, e_cg);
    chk("ram_en", ram_en, e_dg | e_cg);
    chk("ram_we", ram_we, e_cg);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_wdata", ram_wdata, e_wdata);
    chk("disp_rvalid", disp_rvalid, rst_n && m_rv);
    chk("preempt_cnt", preempt_cnt, rst_n ? m_pre : 0);
    chk("cap_starved", cap_starved, rst_n && m_starved);
    chk("disp_rdata_passthru", disp_rdata, ram_rdata);
    if (rst_n && m_rv) chk("disp_rdata", disp_rdata, m_rv_data);
  endtask

  task automatic model_update();
    bit dg, cg, pre, re;
    int nxt, nw;
    if (!rst_n) begin
      m_owner = M_IDLE; m_burst = 0; m_wait = 0; m_pre = 0; m_starved = 0;
      m_rv = 0; m_last_dg = 0; m_last_cg = 0; m_last_pre = 0;
      return;
    end
    dg  = disp_req && (m_owner == M_DISP);
    cg  = cap_req && (m_owner == M_CAP);
    pre = 0;
    re  = 0;
    nxt = M_IDLE;
    if (m_owner == M_IDLE) begin
      nxt = disp_req ? M_DISP : (cap_req ? M_CAP : M_IDLE);
    end else if (m_owner == M_DISP) begin
      if (cap_req && m_wait >= MAXW) begin nxt = M_CAP; pre = 1; end
      else if (disp_req) nxt = M_DISP;
      else if (cap_req) nxt = M_CAP;
      else nxt = M_IDLE;
    end else begin
      if (cap_req && m_burst < BLEN - 1) nxt = M_CAP;
      else if (disp_req) nxt = M_DISP;
      else if (cap_req) begin nxt = M_CAP; re = 1; end
      else nxt = M_IDLE;
    end
    if (nxt != M_CAP || re) m_burst = 0;
    else if (cg) m_burst++;
    nw = cg ? 0 : (cap_req ? ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1) : m_wait);
    m_wait = nw;
    if (stat_clr) begin
      m_pre = 0;
      m_starved = 0;
    end else begin
      if (pre && m_pre < 65535) m_pre++;
      if (nw == MAXW) m_starved = 1;
    end
    m_rv = dg;
    if (dg) m_rv_data = expected_word(disp_addr);
    if (cg) begin
      shadow[cap_addr] = cap_wdata;
      sh_wr[cap_addr]  = 1;
    end
    m_owner = nxt;
    m_last_dg = dg; m_last_cg = cg; m_last_pre = pre;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a, k, r, rv, guard, we_cnt, ndg, t, first_cg, ncw, regain, got;
    logic [7:0] capd [20];
    seed = int'($urandom_range(0, 255));

    // Reset with both requesters asking: nothing may be granted.
    disp_req = 1; cap_req = 1;
    repeat (3) tick();
    rst_n = 1; cap_req = 0; disp_addr = 0;
    n = 0;
    while (n < 10) begin
      tick(); n++;
      if (obs_dg) break;
    end
    chk("first_gnt_latency", n, 2);

    // Display-only stream over the whole buffer.
    a = 1; disp_addr = 10'(a); guard = 0; ndg = 0;
    while (a < 1024 && guard < 1100) begin
      tick(); guard++;
      if (obs_dg) ndg++;
      if (m_last_dg) begin
        a++;
        if (a < 1024) disp_addr = 10'(a);
        else disp_req = 0;
      end
    end
    chk("disp_stream_cycles", guard, 1023);
    chk("disp_stream_gnts", ndg, 1023);

    // Capture-only: 20 writes at 700..719, bursts re-entered without gaps.
    for (int i = 0; i < 20; i++) capd[i] = 8'($urandom);
    cap_req = 1; cap_addr = 700; cap_wdata = capd[0]; k = 0; guard = 0; we_cnt = 0;
    while (k < 20 && guard < 60) begin
      tick(); guard++;
      if (obs_we) we_cnt++;
      if (m_last_cg) begin
        k++;
        if (k < 20) begin cap_addr = 10'(700 + k); cap_wdata = capd[k]; end
        else cap_req = 0;
      end
    end
    chk("cap_burst_cycles", guard, 21);
    repeat (3) begin tick(); if (obs_we) we_cnt++; end
    chk("cap_we_cycles", we_cnt, 20);

    disp_req = 1; disp_addr = 700; r = 0; rv = 0; guard = 0;
    while ((r < 20 || rv < 20) && guard < 60) begin
      tick(); guard++;
      if (obs_rv && rv < 20) begin chk("readback", obs_rdata, capd[rv]); rv++; end
      if (m_last_dg && r < 20) begin
        r++;
        if (r < 20) disp_addr = 10'(700 + r);
        else disp_req = 0;
      end
    end
    chk("readback_count", rv, 20);

    // Contention: display continuous, capture from relative cycle 5.
    rst_n = 0; disp_req = 0; cap_req = 0; tick(); rst_n = 1;
    disp_req = 1; disp_addr = 10'($urandom_range(0, 1023));
    first_cg = -1; ncw = 0; regain = -1; t = 0;
    while (t < 120 && regain < 0) begin
      if (t == 5) begin
        cap_req = 1; cap_addr = 10'(300 + $urandom_range(0, 99)); cap_wdata = 8'($urandom);
      end
      tick();
      if (obs_cg) begin if (first_cg < 0) first_cg = t; ncw++; end
      if (obs_dg && first_cg >= 0) regain = t;
      if (m_last_dg) disp_addr = 10'($urandom_range(0, 1023));
      if (m_last_cg) begin cap_addr = 10'(300 + $urandom_range(0, 99)); cap_wdata = 8'($urandom); end
      t++;
    end
    chk("preempt_gnt_cycle", first_cg, 38);
    chk("burst_writes_before_regain", ncw, 8);
    chk("regain_cycle", regain, 46);
    chk("contention_preempt_cnt", obs_pre, 1);
    chk("contention_starved", obs_st, 1);

    // Simultaneous request from idle, then stat_clr against a preemption.
    rst_n = 0; disp_req = 0; cap_req = 0; tick(); rst_n = 1;
    disp_req = 1; disp_addr = 10'($urandom_range(0, 1023));
    cap_req = 1; cap_addr = 10'(300 + $urandom_range(0, 99)); cap_wdata = 8'($urandom);
    tick();
    tick();
    chk("simul_disp_wins", obs_dg, 1);
    chk("simul_cap_waits", obs_cg, 0);
    if (m_last_dg) disp_addr = 10'($urandom_range(0, 1023));
    got = 0; guard = 0;
    while (!got && guard < 80) begin
      stat_clr = (m_owner == M_DISP) && cap_req && (m_wait >= MAXW);
      tick(); guard++;
      stat_clr = 0;
      if (m_last_pre) got = 1;
      if (m_last_dg) disp_addr = 10'($urandom_range(0, 1023));
      if (m_last_cg) begin cap_addr = 10'(300 + $urandom_range(0, 99)); cap_wdata = 8'($urandom); end
    end
    tick();
    chk("stat_clr_wins", obs_pre, 0);
    chk("stat_clr_starved", obs_st, 0);
    chk("preempt_after_clr", obs_cg, 1);

    // Reset in the middle of a capture burst (3rd write pending).
    rst_n = 0; disp_req = 0; cap_req = 0; tick(); rst_n = 1;
    cap_req = 1; cap_addr = 900; cap_wdata = 8'($urandom); k = 0; guard = 0;
    while (k < 2 && guard < 20) begin
      tick(); guard++;
      if (m_last_cg) begin k++; cap_addr = 10'(900 + k); cap_wdata = 8'($urandom); end
    end
    rst_n = 0;
    tick();
    chk("mid_burst_gnt_dropped", obs_cg, 0);
    tick();
    chk("mid_burst_ram_en", obs_en, 0);
    chk("mid_burst_rvalid", obs_rv, 0);
    chk("mid_burst_preempt", obs_pre, 0);
    chk("mid_burst_starved", obs_st, 0);
    chk("mid_burst_2nd_written", written[901], 1);
    chk("mid_burst_3rd_dropped", written[902], 0);

    // Reset right after a display grant flushes the pending rvalid.
    rst_n = 1; cap_req = 0; disp_req = 1; disp_addr = 10'($urandom_range(0, 1023)); guard = 0;
    while (guard < 10) begin
      tick(); guard++;
      if (obs_dg) break;
    end
    rst_n = 0;
    tick();
    chk("flush_rvalid", obs_rv, 0);
    rst_n = 1; disp_req = 0;
    tick();

    // Random traffic under the handshake rules.
    for (int i = 0; i < 600; i++) begin
      if (!disp_req && $urandom_range(0, 2) == 0) begin
        disp_req = 1; disp_addr = 10'($urandom_range(0, 1023));
      end
      if (!cap_req && $urandom_range(0, 3) == 0) begin
        cap_req = 1; cap_addr = 10'($urandom_range(0, 1023)); cap_wdata = 8'($urandom);
      end
      stat_clr = ($urandom_range(0, 40) == 0);
      tick();
      stat_clr = 0;
      if (m_last_dg) begin
        if ($urandom_range(0, 3) == 0) disp_req = 0;
        else disp_addr = 10'($urandom_range(0, 1023));
      end
      if (m_last_cg) begin
        if ($urandom_range(0, 5) == 0) cap_req = 0;
        else begin cap_addr = 10'($urandom_range(0, 1023)); cap_wdata = 8'($urandom); end
      end
    end
    disp_req = 0; cap_req = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
